decoder_rr_scheduler: RTL and testbench

DECODER_RR_SCHEDULER -- requirements
Module: decoder_rr_scheduler

---
 rtl/decoder_rr_scheduler.sv | 117 +++++++++++
 tb/tb_decoder_rr_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/decoder_rr_scheduler.sv
// Round-robin scheduler for eight requesters that drives a 3-to-8 decoder
// (sel/sel_en) plus a matching one-hot grant, with a hold limit and a dead GAP cycle.
module decoder_rr_scheduler #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic [7:0] grant,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] sel_n;
  logic       sel_en_n;
  logic [7:0] grant_n;
  logic       timeout_n;
  logic [7:0] hold_cnt, hold_n;

  logic [2:0] winner;
  logic [2:0] cand;
  logic       win_found;

  // Circular priority search starting at ptr: first active requester wins.
  always_comb begin
    winner    = ptr;
    cand      = ptr;
    win_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    sel_en_n  = 1'b0;
    grant_n   = 8'h00;
    timeout_n = 1'b0;
    hold_n    = hold_cnt;
    unique case (state)
      IDLE, GAP: begin
        if (EN && win_found) begin
          state_n  = GRANT;
          sel_n    = winner;
          sel_en_n = 1'b1;
          grant_n  = 8'b1 << winner;
          hold_n   = 8'd1;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_n = GAP;
          ptr_n   = sel + 3'd1;
        end else if (hold_cnt == HOLD_LIMIT) begin
          state_n   = GAP;
          ptr_n     = sel + 3'd1;
          timeout_n = 1'b1;
        end else begin
          // EN and other requests are ignored here: the owner is never preempted.
          sel_en_n = 1'b1;
          grant_n  = grant;
          hold_n   = hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the asynchronous reset clears all of it, which also
  // drops grant immediately and suppresses any pending timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      sel_en   <= 1'b0;
      grant    <= 8'h00;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      sel_en   <= sel_en_n;
      grant    <= grant_n;
      timeout  <= timeout_n;
      hold_cnt <= hold_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Scoreboard bench for decoder_rr_scheduler: directed steps queue expected outputs,
// a negedge monitor pops and compares them and checks grant/sel consistency every cycle.
module tb_decoder_rr_scheduler;

  localparam int MH = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req_l;
  logic [2:0] sel;
  logic       sel_en;
  logic [7:0] grant;
  logic       timeout;
  logic       busy;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       sel_en;
    logic       timeout;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  decoder_rr_scheduler #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .EN      (en),
    .req     (req_l),
    .sel     (sel),
    .sel_en  (sel_en),
    .grant   (grant),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    check_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Drive inputs for one edge and queue the outputs expected after it.
  task automatic step(input logic ei, input logic [7:0] r, input logic [7:0] g,
                      input logic [2:0] s, input logic to, input logic bz);
    exp_t x;
    en    = ei;
    req_l = r;
    @(posedge clk);
    x.grant   = g;
    x.sel     = s;
    x.sel_en  = |g;
    x.timeout = to;
    x.busy    = bz;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h00);
    check({tag, "_sel"}, 32'(sel), 32'h0);
    check({tag, "_sel_en"}, 32'(sel_en), 32'h0);
    check({tag, "_timeout"}, 32'(timeout), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(grant)), 32'h1);
    check("grant_vs_sel", 32'(grant), sel_en ? 32'(8'b1 << sel) : 32'h0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("sel", 32'(sel), 32'(e.sel));
      check("sel_en", 32'(sel_en), 32'(e.sel_en));
      check("timeout", 32'(timeout), 32'(e.timeout));
      check("busy", 32'(busy), 32'(e.busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    req_l = 8'h00;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic grant, release, pointer advance.
    step(1, 8'h24, 8'h04, 3'd2, 0, 1);
    step(1, 8'h20, 8'h00, 3'd2, 0, 1);
    step(1, 8'h20, 8'h20, 3'd5, 0, 1);
    step(1, 8'h00, 8'h00, 3'd5, 0, 1);
    step(0, 8'h00, 8'h00, 3'd5, 0, 0);

    // Single persistent requester hits the hold limit.
    step(1, 8'h01, 8'h01, 3'd0, 0, 1);
    step(1, 8'h01, 8'h01, 3'd0, 0, 1);
    step(1, 8'h01, 8'h01, 3'd0, 0, 1);
    step(1, 8'h01, 8'h00, 3'd0, 1, 1);
    step(1, 8'h01, 8'h01, 3'd0, 0, 1);
    step(1, 8'h01, 8'h01, 3'd0, 0, 1);
    step(1, 8'h00, 8'h00, 3'd0, 0, 1);
    step(1, 8'h00, 8'h00, 3'd0, 0, 0);

    // Park ptr at 0 via requester 7, then full rotation with req=FF.
    step(1, 8'h80, 8'h80, 3'd7, 0, 1);
    step(1, 8'h00, 8'h00, 3'd7, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'hFF, 8'(1 << i), 3'(i), 0, 1);
      step(1, 8'hFF & ~8'(1 << i), 8'h00, 3'(i), 0, 1);
    end
    step(1, 8'hFF, 8'h01, 3'd0, 0, 1);
    step(1, 8'h00, 8'h00, 3'd0, 0, 1);
    step(1, 8'h00, 8'h00, 3'd0, 0, 0);

    // EN gating: blocks new grants only.
    step(0, 8'h10, 8'h00, 3'd0, 0, 0);
    step(0, 8'h10, 8'h00, 3'd0, 0, 0);
    step(1, 8'h10, 8'h10, 3'd4, 0, 1);
    step(0, 8'h10, 8'h10, 3'd4, 0, 1);
    step(0, 8'h10, 8'h10, 3'd4, 0, 1);
    step(0, 8'h00, 8'h00, 3'd4, 0, 1);
    step(0, 8'h10, 8'h00, 3'd4, 0, 0);
    step(0, 8'h00, 8'h00, 3'd4, 0, 0);

    // Asynchronous reset in the middle of a grant to requester 6.
    step(1, 8'h40, 8'h40, 3'd6, 0, 1);
    step(1, 8'h40, 8'h40, 3'd6, 0, 1);
    rst_n = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'hC0, 8'h40, 3'd6, 0, 1);
    step(1, 8'h00, 8'h00, 3'd6, 0, 1);
    step(1, 8'h00, 8'h00, 3'd6, 0, 0);

    repeat (4) @(negedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
